// File: rtl/vga_pkg.sv
// Shared VGA timing types and 640x480@60 defaults.
package vga_pkg;

  typedef enum logic [1:0] {PH_ACTIVE, PH_FP, PH_SYNC, PH_BP} vga_phase_e;

  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } vga_axis_t;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Counter width covering the longest phase; never narrower than 1 bit.
  function automatic int cnt_width(int a, int b, int c, int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/vga_axis_fsm.sv
// One raster axis: ACTIVE -> FP -> SYNC -> BP phases, each LEN steps long.
module vga_axis_fsm
  import vga_pkg::*;
#(
  parameter int LEN_ACTIVE = H_ACTIVE_DEF,
  parameter int LEN_FP     = H_FP_DEF,
  parameter int LEN_SYNC   = H_SYNC_DEF,
  parameter int LEN_BP     = H_BP_DEF,
  localparam int CW        = cnt_width(LEN_ACTIVE, LEN_FP, LEN_SYNC, LEN_BP)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          step_i,
  output vga_phase_e    phase_o,
  output logic [CW-1:0] cnt_o,
  output logic          last_o,
  output logic          active_last_o
);

  vga_phase_e    r_phase, w_phase_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_len_m1;
  logic          w_at_end;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_phase <= PH_ACTIVE;
      r_cnt   <= '0;
    end else begin
      r_phase <= w_phase_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_len_m1    = CW'(LEN_ACTIVE - 1);
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_cnt;
    case (r_phase)
      PH_ACTIVE: w_len_m1 = CW'(LEN_ACTIVE - 1);
      PH_FP:     w_len_m1 = CW'(LEN_FP - 1);
      PH_SYNC:   w_len_m1 = CW'(LEN_SYNC - 1);
      PH_BP:     w_len_m1 = CW'(LEN_BP - 1);
      default:   w_len_m1 = CW'(LEN_ACTIVE - 1);
    endcase
    w_at_end = (r_cnt == w_len_m1);
    if (step_i) begin
      if (w_at_end) begin
        w_cnt_nxt = '0;
        case (r_phase)
          PH_ACTIVE: w_phase_nxt = PH_FP;
          PH_FP:     w_phase_nxt = PH_SYNC;
          PH_SYNC:   w_phase_nxt = PH_BP;
          default:   w_phase_nxt = PH_ACTIVE;
        endcase
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  assign phase_o       = r_phase;
  assign cnt_o         = r_cnt;
  assign last_o        = (r_phase == PH_BP) && w_at_end;
  assign active_last_o = (r_phase == PH_ACTIVE) && w_at_end;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: registered sync, data-enable and line/frame pulses.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ce_i,
  output logic hsync_o,
  output logic vsync_o,
  output logic de_o,
  output logic eol_o,
  output logic eof_o,
  output logic sof_o
);

  localparam vga_axis_t H_CFG = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam vga_axis_t V_CFG = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
  localparam int HCW = cnt_width(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VCW = cnt_width(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_len
    $error("vga_timing_gen: every phase length must be >= 1");
  end

  vga_phase_e     w_h_phase, w_v_phase;
  logic [HCW-1:0] w_h_cnt;
  logic [VCW-1:0] w_v_cnt;
  logic           w_h_last, w_h_alast, w_v_last, w_v_alast, w_v_step, w_de;

  // Vertical advances once per line, on the final horizontal step.
  assign w_v_step = ce_i & w_h_last;

  vga_axis_fsm #(
    .LEN_ACTIVE(H_CFG.active), .LEN_FP(H_CFG.fp), .LEN_SYNC(H_CFG.sync), .LEN_BP(H_CFG.bp)
  ) u_h (
    .clk_i(clk_i), .rst_ni(rst_ni), .step_i(ce_i),
    .phase_o(w_h_phase), .cnt_o(w_h_cnt), .last_o(w_h_last), .active_last_o(w_h_alast)
  );

  vga_axis_fsm #(
    .LEN_ACTIVE(V_CFG.active), .LEN_FP(V_CFG.fp), .LEN_SYNC(V_CFG.sync), .LEN_BP(V_CFG.bp)
  ) u_v (
    .clk_i(clk_i), .rst_ni(rst_ni), .step_i(w_v_step),
    .phase_o(w_v_phase), .cnt_o(w_v_cnt), .last_o(w_v_last), .active_last_o(w_v_alast)
  );

  assign w_de = (w_h_phase == PH_ACTIVE) && (w_v_phase == PH_ACTIVE);

  // Pulses are cleared on idle cycles so each event is reported exactly once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hsync_o <= ~HSYNC_POL;
      vsync_o <= ~VSYNC_POL;
      de_o    <= 1'b0;
      eol_o   <= 1'b0;
      eof_o   <= 1'b0;
      sof_o   <= 1'b0;
    end else if (ce_i) begin
      hsync_o <= (w_h_phase == PH_SYNC) ? HSYNC_POL : ~HSYNC_POL;
      vsync_o <= (w_v_phase == PH_SYNC) ? VSYNC_POL : ~VSYNC_POL;
      de_o    <= w_de;
      eol_o   <= w_de & w_h_alast;
      eof_o   <= w_de & w_h_alast & w_v_alast;
      sof_o   <= w_de && (w_h_cnt == '0) && (w_v_cnt == '0);
    end else begin
      eol_o   <= 1'b0;
      eof_o   <= 1'b0;
      sof_o   <= 1'b0;
    end
  end

  logic w_unused;
  assign w_unused = w_v_last;

endmodule
